// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: selects a start address, steps/branches
// the PC through the instruction ROM and stops on the all-ones halt word.
module fetch_sequencer #(
    parameter int A      = 10,
    parameter int W      = 9,
    parameter int CW     = 16,
    parameter int START0 = 0,
    parameter int START1 = 256,
    parameter int START2 = 512,
    parameter int START3 = 768
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [A-1:0]  Target,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [A-1:0]  pc, pc_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [A-1:0]  start_addr;
    logic          halt;

    always_comb begin
        case (ProgSel)
            2'd0:    start_addr = A'(START0);
            2'd1:    start_addr = A'(START1);
            2'd2:    start_addr = A'(START2);
            default: start_addr = A'(START3);
        endcase
    end

    assign halt = (InstIn == '1);

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        cnt_nx    = cnt;
        InstValid = 1'b0;
        case (state)
            RUN: begin
                // Every RUN cycle counts, stalled and halt cycles included.
                if (cnt != '1)
                    cnt_nx = cnt + 1'b1;
                if (!Stall) begin
                    InstValid = 1'b1;
                    if (halt)
                        state_nx = DONE;
                    else if (BranchEn && !BranchRel)
                        pc_nx = Target;
                    else if (BranchEn && BranchRel)
                        pc_nx = pc + Target;
                    else
                        pc_nx = pc + 1'b1;
                end
            end
            default: begin
                if (Start) begin
                    state_nx = RUN;
                    pc_nx    = start_addr;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cnt   <= cnt_nx;
        end
    end

    assign InstAddress = pc;
    assign Done        = (state == DONE);
    assign CycleCount  = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a table-driven ROM and branch model.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start, Stall;
    logic [1:0]  ProgSel;
    logic        BranchEn, BranchRel;
    logic [9:0]  Target;
    logic [8:0]  InstIn;
    logic [9:0]  InstAddress;
    logic        InstValid, Done;
    logic [15:0] CycleCount;

    logic        s_start;
    logic [9:0]  s_addr;
    logic        s_valid, s_done;
    logic [3:0]  s_cnt;

    logic [8:0]  rom    [1024];
    logic        br_en  [1024];
    logic        br_rel [1024];
    logic [9:0]  br_tgt [1024];

    int vectors = 0;
    int errors  = 0;

    always #5 Clk = ~Clk;

    assign InstIn    = rom[InstAddress];
    assign BranchEn  = br_en[InstAddress];
    assign BranchRel = br_rel[InstAddress];
    assign Target    = br_tgt[InstAddress];

    fetch_sequencer #(.A(10), .W(9), .CW(16), .START0(0), .START1(256),
                      .START2(512), .START3(768)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .Stall(Stall), .BranchEn(BranchEn), .BranchRel(BranchRel),
        .Target(Target), .InstIn(InstIn), .InstAddress(InstAddress),
        .InstValid(InstValid), .Done(Done), .CycleCount(CycleCount)
    );

    // Narrow counter instance to reach saturation in a handful of cycles.
    fetch_sequencer #(.A(10), .W(9), .CW(4)) dut_s (
        .Clk(Clk), .Reset(Reset), .Start(s_start), .ProgSel(2'd0),
        .Stall(1'b0), .BranchEn(1'b0), .BranchRel(1'b0),
        .Target(10'd0), .InstIn(9'd0), .InstAddress(s_addr),
        .InstValid(s_valid), .Done(s_done), .CycleCount(s_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'd0; br_en[i] = 1'b0; br_rel[i] = 1'b0; br_tgt[i] = 10'd0;
        end
    endtask

    task automatic test_reset();
        clear_rom();
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; ProgSel = 2'd0; s_start = 1'b0;
        tick(); tick();
        vectors++;
        if (InstAddress !== 10'd0 || Done !== 1'b0 || CycleCount !== 16'd0 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%0d done=%b cnt=%0d valid=%b, want 0 0 0 0",
                     InstAddress, Done, CycleCount, InstValid);
        end
        Reset = 1'b0;
    endtask

    task automatic test_linear();
        rom[515] = '1;
        Start = 1'b1; ProgSel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            Start = 1'b0;
            vectors++;
            if (InstAddress !== 10'(512 + i) || InstValid !== 1'b1 || CycleCount !== 16'(i)) begin
                errors++;
                $display("FAIL linear step %0d: addr=%0d valid=%b cnt=%0d, want %0d 1 %0d",
                         i, InstAddress, InstValid, CycleCount, 512 + i, i);
            end
        end
        tick();
        vectors++;
        if (Done !== 1'b1 || CycleCount !== 16'd4 || InstAddress !== 10'd515 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL linear halt: done=%b cnt=%0d addr=%0d valid=%b, want 1 4 515 0",
                     Done, CycleCount, InstAddress, InstValid);
        end
        tick();
        vectors++;
        if (Done !== 1'b1 || CycleCount !== 16'd4 || InstAddress !== 10'd515) begin
            errors++;
            $display("FAIL done hold: done=%b cnt=%0d addr=%0d, want 1 4 515",
                     Done, CycleCount, InstAddress);
        end
    endtask

    task automatic test_abs_branch();
        logic [9:0] exp_seq [5];
        exp_seq = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd10};
        clear_rom();
        br_en[3] = 1'b1; br_tgt[3] = 10'd10; rom[10] = '1;
        Start = 1'b1; ProgSel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            Start = 1'b0;
            vectors++;
            if (InstAddress !== exp_seq[i] || Done !== 1'b0) begin
                errors++;
                $display("FAIL abs branch step %0d: addr=%0d done=%b, want %0d 0",
                         i, InstAddress, Done, exp_seq[i]);
            end
        end
        tick();
        vectors++;
        if (Done !== 1'b1 || CycleCount !== 16'd5 || InstAddress !== 10'd10) begin
            errors++;
            $display("FAIL abs branch halt: done=%b cnt=%0d addr=%0d, want 1 5 10",
                     Done, CycleCount, InstAddress);
        end
    endtask

    task automatic test_rel_branch_and_wrap();
        logic [9:0] loop_seq [7];
        logic [9:0] wrap_seq [5];
        loop_seq = '{10'd256, 10'd257, 10'd258, 10'd259, 10'd260, 10'd256, 10'd257};
        wrap_seq = '{10'd768, 10'd1022, 10'd1023, 10'd0, 10'd1};
        clear_rom();
        br_en[260] = 1'b1; br_rel[260] = 1'b1; br_tgt[260] = 10'h3FC;
        Start = 1'b1; ProgSel = 2'd1;
        for (int i = 0; i < 7; i++) begin
            tick();
            // Held Start with another program select must not disturb RUN.
            ProgSel = 2'd3;
            vectors++;
            if (InstAddress !== loop_seq[i]) begin
                errors++;
                $display("FAIL rel branch step %0d: addr=%0d, want %0d",
                         i, InstAddress, loop_seq[i]);
            end
        end
        Start = 1'b0;
        Reset = 1'b1; tick(); Reset = 1'b0;
        clear_rom();
        br_en[768] = 1'b1; br_tgt[768] = 10'd1022; rom[1] = '1;
        Start = 1'b1; ProgSel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            Start = 1'b0;
            vectors++;
            if (InstAddress !== wrap_seq[i]) begin
                errors++;
                $display("FAIL wrap step %0d: addr=%0d, want %0d", i, InstAddress, wrap_seq[i]);
            end
        end
        tick();
        vectors++;
        if (Done !== 1'b1 || CycleCount !== 16'd5) begin
            errors++;
            $display("FAIL wrap halt: done=%b cnt=%0d, want 1 5", Done, CycleCount);
        end
    endtask

    task automatic test_stall();
        clear_rom();
        rom[5] = '1; br_en[5] = 1'b1; br_tgt[5] = 10'd50;
        Start = 1'b1; ProgSel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            Start = 1'b0;
        end
        vectors++;
        if (InstAddress !== 10'd5 || CycleCount !== 16'd5) begin
            errors++;
            $display("FAIL stall entry: addr=%0d cnt=%0d, want 5 5", InstAddress, CycleCount);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (InstValid !== 1'b0 || InstAddress !== 10'd5 || Done !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: valid=%b addr=%0d done=%b, want 0 5 0",
                         i, InstValid, InstAddress, Done);
            end
            tick();
        end
        Stall = 1'b0;
        #1;
        vectors++;
        if (InstValid !== 1'b1 || CycleCount !== 16'd8) begin
            errors++;
            $display("FAIL stall release: valid=%b cnt=%0d, want 1 8", InstValid, CycleCount);
        end
        tick();
        vectors++;
        if (Done !== 1'b1 || CycleCount !== 16'd9 || InstAddress !== 10'd5) begin
            errors++;
            $display("FAIL stall halt: done=%b cnt=%0d addr=%0d, want 1 9 5",
                     Done, CycleCount, InstAddress);
        end
    endtask

    task automatic test_mid_run_reset();
        clear_rom();
        br_en[0] = 1'b1; br_tgt[0] = 10'd99;
        br_en[100] = 1'b1; br_tgt[100] = 10'd300;
        Start = 1'b1; ProgSel = 2'd0;
        tick(); Start = 1'b0;
        tick(); tick();
        vectors++;
        if (InstAddress !== 10'd100 || Done !== 1'b0) begin
            errors++;
            $display("FAIL pre-reset: addr=%0d done=%b, want 100 0", InstAddress, Done);
        end
        Reset = 1'b1;
        tick();
        vectors++;
        if (InstAddress !== 10'd0 || CycleCount !== 16'd0 || Done !== 1'b0 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL mid-run reset: addr=%0d cnt=%0d done=%b valid=%b, want 0 0 0 0",
                     InstAddress, CycleCount, Done, InstValid);
        end
        Start = 1'b1; ProgSel = 2'd2;
        tick();
        vectors++;
        if (InstAddress !== 10'd0 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL reset beats start: addr=%0d valid=%b, want 0 0", InstAddress, InstValid);
        end
        Reset = 1'b0; Start = 1'b0;
        tick();
        vectors++;
        if (InstAddress !== 10'd0 || InstValid !== 1'b0 || CycleCount !== 16'd0) begin
            errors++;
            $display("FAIL idle hold: addr=%0d valid=%b cnt=%0d, want 0 0 0",
                     InstAddress, InstValid, CycleCount);
        end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        vectors++;
        if (s_cnt !== 4'd14 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat pre: cnt=%0d valid=%b, want 14 1", s_cnt, s_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (s_cnt !== 4'd15) begin
                errors++;
                $display("FAIL sat step %0d: cnt=%0d, want 15", i, s_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_abs_branch();
        test_rel_branch_and_wrap();
        test_stall();
        test_mid_run_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
